// File: rtl/mul_div_seq_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface mul_div_seq_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FLAG_W = 16
);
  logic              start;
  logic [4:0]        opcode;
  logic [WIDTH-1:0]  operand_1;
  logic [WIDTH-1:0]  operand_2;
  logic [FLAG_W-1:0] current_flags;
  logic              ready;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result_0;
  logic [WIDTH-1:0]  result_1;
  logic [FLAG_W-1:0] next_flags;
  logic              flag_we;

  modport master (
    output start, opcode, operand_1, operand_2, current_flags,
    input  ready, busy, done, result_0, result_1, next_flags, flag_we
  );

  modport slave (
    input  start, opcode, operand_1, operand_2, current_flags,
    output ready, busy, done, result_0, result_1, next_flags, flag_we
  );
endinterface

// File: rtl/mul_div_seq_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider with flag update.
// Optional macro MUL_DIV_EARLY_TERM_EN: multiply exits once remaining multiplier bits are zero.
module mul_div_seq_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FLAG_W  = 16,
  parameter logic [4:0]  OPC_MUL = 5'd5,
  parameter logic [4:0]  OPC_DIV = 5'd6
) (
  input logic             clk,
  input logic             reset,
  mul_div_seq_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_op2;
  logic [FLAG_W-1:0]   r_flags;
  logic [WIDTH-1:0]    r_result_0, r_result_1;
  logic [FLAG_W-1:0]   r_next_flags;

  logic                w_is_mul, w_is_div, w_accept, w_div_zero, w_last;
  logic [WIDTH:0]      w_mul_sum;
  logic [2*WIDTH-1:0]  w_mul_next;
  logic [WIDTH:0]      w_div_sh;
  logic                w_div_ge;
  logic [WIDTH-1:0]    w_div_diff, w_div_rem;
  logic [2*WIDTH-1:0]  w_div_next;
  logic                w_fin, w_fin_mul, w_ovf;
  logic [WIDTH-1:0]    w_res0, w_res1;
  logic [FLAG_W-1:0]   w_base_flags, w_new_flags;
  logic [2*WIDTH-1:0]  w_product;

  assign w_is_mul   = (bus.opcode == OPC_MUL);
  assign w_is_div   = (bus.opcode == OPC_DIV);
  assign w_accept   = (r_state == IDLE) && bus.start && (w_is_mul || w_is_div);
  assign w_div_zero = w_is_div && (bus.operand_2 == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply step: add into the upper half, carry lands in bit 31 after the shift.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_op2[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step on {remainder, dividend/quotient}.
  assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_op2});
  assign w_div_diff = w_div_sh[WIDTH-1:0] - r_op2;
  assign w_div_rem  = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

`ifdef MUL_DIV_EARLY_TERM_EN
  logic             w_mul_early;
  logic [CNT_W-1:0] w_shamt;
  assign w_mul_early = (r_op2[WIDTH-1:1] == '0);
  assign w_shamt     = CNT_W'(WIDTH - 1) - r_cnt;
  // Remaining right shifts are applied in one step so the product matches the full run.
  assign w_product   = w_mul_next >> w_shamt;
  assign w_fin_mul   = w_last || w_mul_early;
`else
  assign w_product   = w_mul_next;
  assign w_fin_mul   = w_last;
`endif

  // Completion detection and result/flag formation for the edge that enters DONE.
  always_comb begin
    w_fin        = 1'b0;
    w_res0       = '0;
    w_res1       = '0;
    w_ovf        = 1'b0;
    w_base_flags = r_flags;
    case (r_state)
      IDLE: begin
        w_fin        = w_accept && w_div_zero;
        w_res0       = '1;
        w_res1       = bus.operand_1;
        w_ovf        = 1'b1;
        w_base_flags = bus.current_flags;
      end
      MUL_RUN: begin
        w_fin  = w_fin_mul;
        w_res0 = w_product[WIDTH-1:0];
        w_res1 = w_product[2*WIDTH-1:WIDTH];
      end
      DIV_RUN: begin
        w_fin  = w_last;
        w_res0 = w_div_next[WIDTH-1:0];
        w_res1 = w_div_next[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
    w_new_flags    = w_base_flags;
    w_new_flags[0] = (r_state == MUL_RUN) && (w_res1 != '0);
    w_new_flags[1] = w_ovf;
    w_new_flags[7] = (w_res0 == '0) && (w_res1 == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_div_zero)    w_state_next = DONE;
          else if (w_is_mul) w_state_next = MUL_RUN;
          else               w_state_next = DIV_RUN;
        end
      end
      MUL_RUN, DIV_RUN: if (w_fin) w_state_next = DONE;
      DONE:             w_state_next = IDLE;
      default:          w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready   = (r_state == IDLE);
    bus.busy    = (r_state == MUL_RUN) || (r_state == DIV_RUN);
    bus.done    = (r_state == DONE);
    bus.flag_we = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_op2        <= '0;
      r_flags      <= '0;
      r_result_0   <= '0;
      r_result_1   <= '0;
      r_next_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand <= bus.operand_1;
            r_op2   <= bus.operand_2;
            r_flags <= bus.current_flags;
            r_cnt   <= '0;
            r_acc   <= w_is_mul ? '0 : {{WIDTH{1'b0}}, bus.operand_1};
          end
        end
        MUL_RUN: begin
          r_acc <= w_mul_next;
          r_op2 <= r_op2 >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
        DIV_RUN: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
      if (w_fin) begin
        r_result_0   <= w_res0;
        r_result_1   <= w_res1;
        r_next_flags <= w_new_flags;
      end
    end
  end

  assign bus.result_0   = r_result_0;
  assign bus.result_1   = r_result_1;
  assign bus.next_flags = r_next_flags;
endmodule

// File: tb/tb_mul_div_seq_unit.sv
// Scoreboard bench for mul_div_seq_unit: directed vectors with hand-computed results.
module tb_mul_div_seq_unit;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_MUL = 5'd5;
  localparam logic [4:0] OP_DIV = 5'd6;

`ifdef MUL_DIV_EARLY_TERM_EN
  localparam int LAT_1234X3 = 3;
  localparam int LAT_0X5    = 4;
  localparam int LAT_3X3    = 3;
  localparam int LAT_7X0    = 2;
`else
  localparam int LAT_1234X3 = 17;
  localparam int LAT_0X5    = 17;
  localparam int LAT_3X3    = 17;
  localparam int LAT_7X0    = 17;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_seq_unit_if #(.WIDTH(16), .FLAG_W(16)) bus ();

  mul_div_seq_unit #(
    .WIDTH(16), .FLAG_W(16), .OPC_MUL(OP_MUL), .OPC_DIV(OP_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] fl;
    int          lat;
    int          c0;
    int          id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (vector %0d): got 0x%0h expected 0x%0h", name, id, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      if (prev_done) chk("done_width", -1, {31'b0, bus.done}, 32'd0);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", -1, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result_0", e.id, {16'b0, bus.result_0}, {16'b0, e.r0});
          chk("result_1", e.id, {16'b0, bus.result_1}, {16'b0, e.r1});
          chk("next_flags", e.id, {16'b0, bus.next_flags}, {16'b0, e.fl});
          chk("flag_we", e.id, {31'b0, bus.flag_we}, 32'd1);
          chk("latency", e.id, cyc - e.c0 + 1, e.lat);
        end
      end
      prev_done = (bus.done === 1'b1);
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] fl, input bit push, input logic [15:0] e0,
                       input logic [15:0] e1, input logic [15:0] ef, input int lat, input int id);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", id, 32'd0, 32'd1);
    bus.start = 1'b1;
    bus.opcode = op;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.current_flags = fl;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) begin
      e.r0 = e0; e.r1 = e1; e.fl = ef; e.lat = lat; e.c0 = cyc; e.id = id;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb[0].id, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] fl, input logic [15:0] e0, input logic [15:0] e1,
                     input logic [15:0] ef, input int lat, input int id);
    issue(op, a, b, fl, 1'b1, e0, e1, ef, lat, id);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.current_flags = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 0, {31'b0, bus.ready}, 32'd1);
    chk("rst_busy", 0, {31'b0, bus.busy}, 32'd0);
    chk("rst_done", 0, {31'b0, bus.done}, 32'd0);
    chk("rst_flag_we", 0, {31'b0, bus.flag_we}, 32'd0);
    chk("rst_result_0", 0, {16'b0, bus.result_0}, 32'd0);
    chk("rst_result_1", 0, {16'b0, bus.result_1}, 32'd0);
    chk("rst_next_flags", 0, {16'b0, bus.next_flags}, 32'd0);
    reset = 1'b0;

    run(OP_MUL, 16'd10,   16'd20,   16'h0000, 16'h00C8, 16'h0000, 16'h0000, 17, 1);
    run(OP_MUL, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFE, 16'h0001, 16'h0001, 17, 2);
    run(OP_DIV, 16'd20,   16'd5,    16'h0003, 16'h0004, 16'h0000, 16'h0000, 17, 3);
    run(OP_DIV, 16'd40,   16'd29,   16'h8000, 16'h0001, 16'h000B, 16'h8000, 17, 4);
    run(OP_DIV, 16'd20,   16'd0,    16'h0010, 16'hFFFF, 16'h0014, 16'h0012, 1,  5);
    run(OP_MUL, 16'h1234, 16'h0003, 16'h0000, 16'h369C, 16'h0000, 16'h0000, LAT_1234X3, 6);
    run(OP_MUL, 16'h0000, 16'h0005, 16'h0001, 16'h0000, 16'h0000, 16'h0080, LAT_0X5, 7);
    run(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'h0001, 17, 8);
    run(OP_DIV, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 17, 9);
    run(OP_DIV, 16'hFFFF, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 16'h0000, 17, 10);
    run(OP_MUL, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080, LAT_7X0, 11);

    // Non-MUL/DIV opcode must not start anything.
    issue(OP_ADD, 16'd1, 16'd2, 16'h0000, 1'b0, '0, '0, '0, 0, 12);
    repeat (3) @(negedge clk);
    chk("add_ready", 12, {31'b0, bus.ready}, 32'd1);
    chk("add_busy", 12, {31'b0, bus.busy}, 32'd0);

    // A start pulse during busy (div-by-zero request) must be ignored.
    issue(OP_MUL, 16'h1234, 16'h0100, 16'h0000, 1'b1, 16'h3400, 16'h0012, 16'h0001, 17, 13);
    repeat (3) @(negedge clk);
    chk("run_busy", 13, {31'b0, bus.busy}, 32'd1);
    chk("run_ready", 13, {31'b0, bus.ready}, 32'd0);
    bus.start = 1'b1;
    bus.opcode = OP_DIV;
    bus.operand_1 = 16'h5555;
    bus.operand_2 = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    issue(OP_MUL, 16'h1234, 16'h5678, 16'h00FF, 1'b0, '0, '0, '0, 0, 14);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 14, {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_done", 14, {31'b0, bus.done}, 32'd0);
    chk("mid_rst_ready", 14, {31'b0, bus.ready}, 32'd1);
    chk("mid_rst_result_0", 14, {16'b0, bus.result_0}, 32'd0);
    chk("mid_rst_result_1", 14, {16'b0, bus.result_1}, 32'd0);
    chk("mid_rst_next_flags", 14, {16'b0, bus.next_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(OP_MUL, 16'd3, 16'd3, 16'h0000, 16'h0009, 16'h0000, 16'h0000, LAT_3X3, 15);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
